// File: rtl/turn_input_controller.sv
// Turn input controller: turns raw button levels into per-turn action codes plus a one-cycle actionEnable strobe.
// Optional input debounce filter is enabled by defining BTN_DEBOUNCE_EN.
module turn_input_controller #(
  parameter int unsigned TURN_CYCLES     = 1000,
  parameter int unsigned COOLDOWN_CYCLES = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic [3:0] btn1,
  input  logic [3:0] btn2,
  input  logic       gameOver,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       p1Ready,
  output logic       p2Ready,
  output logic [7:0] turnCount
);

  localparam int unsigned TW = $clog2(TURN_CYCLES);
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam bit PARAMS_OK = (TURN_CYCLES >= 2) && (COOLDOWN_CYCLES >= 1) && (DEBOUNCE_CYCLES >= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("turn_input_controller: TURN_CYCLES>=2, COOLDOWN_CYCLES>=1, DEBOUNCE_CYCLES>=1 required");
    end
  endgenerate

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cd;
  logic [7:0]    sync1, sync2, filt, prev;
  logic [7:0]    press;
  logic [2:0]    lat1, lat2;
  logic [2:0]    code1, code2;
  logic          go_issue;

  // Two-flop synchronizer for both players' buttons, player 2 in the upper nibble
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      sync1 <= 8'd0;
      sync2 <= 8'd0;
    end else begin
      sync1 <= {btn2, btn1};
      sync2 <= sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [7:0][DW-1:0] dcnt;

  // Filtered level follows the synced level only after a full run of differing samples
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      filt <= 8'd0;
      dcnt <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] != filt[i]) begin
          if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            filt[i] <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) prev <= 8'd0;
    else            prev <= filt;
  end

  assign press = filt & ~prev;

  function automatic logic [2:0] encode(input logic [3:0] p);
    if (p[3])      return 3'b100;
    else if (p[2]) return 3'b011;
    else if (p[1]) return 3'b010;
    else if (p[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  assign code1    = encode(press[3:0]);
  assign code2    = encode(press[7:4]);
  assign go_issue = (p1Ready && p2Ready) || (timer == TW'(TURN_CYCLES - 1));

  // Turn sequencing; gameOver overrides everything, including a pending issue
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      state        <= COLLECT;
      timer        <= '0;
      cd           <= '0;
      lat1         <= 3'b000;
      lat2         <= 3'b000;
      p1Ready      <= 1'b0;
      p2Ready      <= 1'b0;
      action1      <= 3'b000;
      action2      <= 3'b000;
      actionEnable <= 1'b0;
      turnCount    <= 8'd0;
    end else begin
      actionEnable <= 1'b0;
      if (gameOver) begin
        state   <= HALT;
        p1Ready <= 1'b0;
        p2Ready <= 1'b0;
        lat1    <= 3'b000;
        lat2    <= 3'b000;
      end else begin
        case (state)
          COLLECT: begin
            timer <= timer + TW'(1);
            if (go_issue) begin
              state        <= ISSUE;
              actionEnable <= 1'b1;
              action1      <= p1Ready ? lat1 : 3'b000;
              action2      <= p2Ready ? lat2 : 3'b000;
              turnCount    <= turnCount + 8'd1;
            end else begin
              if (!p1Ready && (code1 != 3'b000)) begin
                p1Ready <= 1'b1;
                lat1    <= code1;
              end
              if (!p2Ready && (code2 != 3'b000)) begin
                p2Ready <= 1'b1;
                lat2    <= code2;
              end
            end
          end
          ISSUE: begin
            state   <= COOLDOWN;
            cd      <= '0;
            p1Ready <= 1'b0;
            p2Ready <= 1'b0;
            lat1    <= 3'b000;
            lat2    <= 3'b000;
          end
          COOLDOWN: begin
            if (cd == CW'(COOLDOWN_CYCLES - 1)) begin
              state <= COLLECT;
              timer <= '0;
            end else begin
              cd <= cd + CW'(1);
            end
          end
          HALT:    state <= HALT;
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule
